vco_band_cal: RTL and testbench
===============================

Name: vco_band_cal

Overview:
- Parametrised successor to the fixed 6-bit FLL coarse-tune path of the VCO system.
- Runs a successive-approximation (SAR) search over a capacitor-bank select code `cfs` of configurable width.
- Each trial code is scored by counting VCO cycles over a programmable reference window and comparing against `n_div*WIN`.
- Reports signed frequency error and lock status. Sits between the divider-ratio source and the analog VCO model; its `cfs` output drives the VCO band input.

Parameters:
- CFS_W, 6: width of the cap-bank select code.
- N_W, 10: width of the divide ratio `n_div`.
- WIN, 32: measurement window length in `ref_clk` cycles (power of two, >=2).
- SETTLE, 8: `ref_clk` cycles waited after each `cfs` change before measuring (>=1).
- CNT_W, 16: width of the VCO count input. Must satisfy CNT_W >= N_W + log2(WIN) + 1.
- TOL, 2: lock tolerance, in VCO counts per window.
- CAP_POL, 1: 1 means a larger `cfs` gives a lower frequency; 0 means a larger `cfs` gives a higher frequency.

Ports:
- ref_clk  in  1  reference clock; only clock of the block.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle pulse; begins calibration when idle.
- n_div  in  N_W  target multiplication ratio; latched on accepted `start`.
- vco_cnt  in  CNT_W  free-running VCO edge count, already synchronised to `ref_clk`, wraps modulo 2^CNT_W.
- cfs  out  CFS_W  cap-bank select code to the VCO.
- busy  out  1  high from the cycle after an accepted `start` until `done`.
- done  out  1  one-cycle pulse when calibration completes.
- locked  out  1  |err| <= TOL on the last measurement.
- err  out  CNT_W+1 signed  last measured count minus target.

Behaviour:
- Reset (asynchronous, any state):
  - `cfs` = 1<<(CFS_W-1) (midscale); `busy`, `done`, `locked` = 0; `err` = 0.
  - State returns to IDLE; all counters and latched values clear.
  - Reset mid-calibration aborts with no `done` pulse.
- Target: `tgt = n_div*WIN`, computed unsigned at CNT_W+1 bits, latched with `n_div` on start.
- States:
  - IDLE:
    - `start` = 1 latches `n_div`, sets trial code = 1<<(CFS_W-1), bit index i = CFS_W-1, and moves to SETL.
    - `cfs` drives the trial code from the next cycle.
  - SETL: counts SETTLE cycles, then moves to SNAP.
  - SNAP: one cycle; captures `snap = vco_cnt`; moves to MEAS.
  - MEAS: WIN cycles.
  - DEC:
    - One cycle. Computes `delta = (vco_cnt - snap) mod 2^CNT_W`, which is correct across wrap-around, and `e = delta - tgt` (signed).
    - SAR step: keep bit i if (CAP_POL=1 and e>=0) or (CAP_POL=0 and e<=0); otherwise clear it.
    - If i>0: set bit i-1, decrement i, go to SETL.
    - If i=0: go to FIN.
  - FIN: drives the final code, then runs SETL/SNAP/MEAS once more with no bit update. Then goes to DONE.
  - DONE:
    - One cycle. Updates `err` and `locked`.
    - `done` = 1, `busy` = 0.
    - Goes to IDLE (or TRACK, see Optional Feature).
- `err` and `locked` update only in DONE, plus TRACK when enabled. They hold otherwise.
- Each step takes SETTLE+WIN+2 cycles. With `start` sampled at cycle t, `done` is high at t + (CFS_W+1)*(SETTLE+WIN+2) + 1. Defaults give t+295.
- `start` while `busy` is ignored. `n_div` changes while `busy` are ignored.
- `n_div` = 0: `tgt` = 0, and the search runs normally. With CAP_POL=1 the result is all-ones.
- Out-of-range targets saturate `cfs` at all-zeros or all-ones; `locked` = 0.

Optional Feature:
- Macro: BAND_CAL_TRACK_EN.
- Enabled:
  - After DONE the FSM enters TRACK instead of IDLE. TRACK repeats SNAP/MEAS/DEC on the current code.
  - Each DEC updates `err` and `locked`.
  - If e > TOL, step `cfs` by one code toward lower frequency (+1 if CAP_POL=1, else -1), saturating at the code limits.
  - If e < -TOL, step one code the opposite way, saturating likewise.
  - After a code change, SETL runs before the next SNAP.
  - `busy` stays 0; `done` does not pulse.
  - `start` in TRACK restarts a full SAR search.
- Disabled: FSM returns to IDLE after DONE and `cfs` holds.

Test Plan:
- VCO model `vco_cnt += 100-cfs` per cycle, defaults, `n_div`=70, `start` at t -> `done` at t+295, `cfs`=30, `err`=0, `locked`=1, `busy` high t+1..t+294.
- Same as above with `vco_cnt` preset to 16'hFFF0 so every window wraps -> identical result, `cfs`=30, `err`=0.
- `n_div`=20 -> `cfs`=63, `err`=+544 ((37-20)*32), `locked`=0. CAP_POL=0 with model 37+cfs and `n_div`=20 -> `cfs`=0, `err`=+544, `locked`=0.
- Second `start` pulse at t+50 during the run is ignored (`done` still at t+295). `rst` pulse at t+100 -> `cfs`=32, `busy`/`done`/`locked`=0 immediately with no clock, no `done` pulse.
- BAND_CAL_TRACK_EN: after lock at `cfs`=30, model changes to 101-cfs -> next DEC `err`=+32, `cfs` becomes 31, following measurement `err`=0, `locked`=1. Without the macro `cfs` stays 30 and `locked` stays 1.

Source files
------------

// File: rtl/vco_band_cal.sv
// SAR coarse-band calibration for the VCO cap bank: picks the cfs code whose counted
// frequency best matches n_div*WIN. Define BAND_CAL_TRACK_EN to enable post-lock tracking.
module vco_band_cal #(
    parameter int CFS_W   = 6,
    parameter int N_W     = 10,
    parameter int WIN     = 32,
    parameter int SETTLE  = 8,
    parameter int CNT_W   = 16,
    parameter int TOL     = 2,
    parameter int CAP_POL = 1
) (
    input  logic                    ref_clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [N_W-1:0]          n_div,
    input  logic [CNT_W-1:0]        vco_cnt,
    output logic [CFS_W-1:0]        cfs,
    output logic                    busy,
    output logic                    done,
    output logic                    locked,
    output logic signed [CNT_W:0]   err
);

    localparam int WIN_LG = $clog2(WIN);
    localparam int TMAX   = (SETTLE > WIN) ? SETTLE : WIN;
    localparam int TW     = $clog2(TMAX + 1);
    localparam int IW     = (CFS_W > 1) ? $clog2(CFS_W) : 1;
    localparam logic [CFS_W-1:0]     MID      = CFS_W'(1) << (CFS_W - 1);
    localparam logic [TW-1:0]        SET_LAST = TW'(SETTLE - 1);
    localparam logic [TW-1:0]        WIN_LAST = TW'(WIN - 1);
    localparam logic signed [CNT_W:0] TOL_P   = (CNT_W + 1)'(TOL);
    localparam logic signed [CNT_W:0] TOL_N   = -TOL_P;

    typedef enum logic [2:0] {IDLE, SETL, SNAP, MEAS, DEC, FIN, DONE, TRACK} state_t;

    state_t                 state, state_n;
    logic [CFS_W-1:0]       code;
    logic [IW-1:0]          bit_idx;
    logic [TW-1:0]          tcnt;
    logic [CNT_W-1:0]       snap;
    logic [CNT_W-1:0]       delta;
    logic [CNT_W:0]         tgt;
    logic                   fin;
    logic                   trk;
    logic signed [CNT_W:0]  err_q;
    logic                   locked_q;

    logic signed [CNT_W:0]  e;
    logic                   in_range, keep, go, upd;
    logic                   hi, lo, up, dn, step_up, step_dn, step;

    assign e        = $signed({1'b0, delta}) - $signed(tgt);
    assign in_range = (e >= TOL_N) && (e <= TOL_P);
    assign keep     = (CAP_POL != 0) ? !e[CNT_W] : (e[CNT_W] || (e == '0));
    assign go       = start && ((state == IDLE) || trk);
    assign upd      = (state == DONE) || (trk && (state == DEC));

    // Tracking steps toward the target by one code, clamped at the bank limits.
    assign hi       = e > TOL_P;
    assign lo       = e < TOL_N;
    assign up       = (CAP_POL != 0) ? hi : lo;
    assign dn       = (CAP_POL != 0) ? lo : hi;
    assign step_up  = up && !(&code);
    assign step_dn  = dn && (code != '0);
    assign step     = step_up || step_dn;

    assign cfs    = code;
    assign err    = upd ? e : err_q;
    assign locked = upd ? in_range : locked_q;

    always_ff @(posedge ref_clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE:  state_n = IDLE;
            SETL:  if (tcnt == SET_LAST) state_n = trk ? TRACK : SNAP;
            SNAP:  state_n = MEAS;
            TRACK: state_n = MEAS;
            MEAS:  if (tcnt == WIN_LAST) state_n = fin ? DONE : DEC;
            DEC: begin
                if (trk)               state_n = step ? SETL : TRACK;
                else if (bit_idx == '0) state_n = FIN;
                else                   state_n = SETL;
            end
            FIN:   state_n = SETL;
            DONE: begin
`ifdef BAND_CAL_TRACK_EN
                state_n = TRACK;
`else
                state_n = IDLE;
`endif
            end
            default: state_n = IDLE;
        endcase
        if (go) state_n = SETL;
        busy = !trk && (state inside {SETL, SNAP, MEAS, DEC, FIN});
        done = (state == DONE);
    end

    always_ff @(posedge ref_clk or posedge rst) begin
        if (rst) begin
            code     <= MID;
            bit_idx  <= '0;
            tcnt     <= '0;
            snap     <= '0;
            delta    <= '0;
            tgt      <= '0;
            fin      <= 1'b0;
            trk      <= 1'b0;
            err_q    <= '0;
            locked_q <= 1'b0;
        end else begin
            if (go) begin
                code    <= MID;
                bit_idx <= IW'(CFS_W - 1);
                tgt     <= (CNT_W + 1)'(n_div) << WIN_LG;
                tcnt    <= '0;
                fin     <= 1'b0;
                trk     <= 1'b0;
            end else begin
                case (state)
                    SETL: tcnt <= (tcnt == SET_LAST) ? '0 : tcnt + 1'b1;
                    SNAP, TRACK: snap <= vco_cnt;
                    MEAS: begin
                        // Modular subtraction keeps the window count valid across counter wrap.
                        if (tcnt == WIN_LAST) begin
                            tcnt  <= '0;
                            delta <= vco_cnt - snap;
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
                    DEC: begin
                        if (trk) begin
                            if (step_up)      code <= code + 1'b1;
                            else if (step_dn) code <= code - 1'b1;
                        end else begin
                            if (!keep) code[bit_idx] <= 1'b0;
                            if (bit_idx != '0) begin
                                code[bit_idx - 1'b1] <= 1'b1;
                                bit_idx              <= bit_idx - 1'b1;
                            end
                        end
                    end
                    FIN:  fin <= 1'b1;
                    DONE: begin
                        fin <= 1'b0;
`ifdef BAND_CAL_TRACK_EN
                        trk <= 1'b1;
`else
                        trk <= 1'b0;
`endif
                    end
                    default: ;
                endcase
            end
            if (upd) begin
                err_q    <= e;
                locked_q <= in_range;
            end
        end
    end

endmodule

// File: tb/tb_vco_band_cal.sv
// Scoreboard bench for vco_band_cal: two instances (CAP_POL=1 and 0) driven by linear VCO models.
module tb_vco_band_cal;

    logic               ref_clk = 1'b0;
    logic               rst;
    logic               start = 1'b0;
    logic [9:0]         n_div = '0;
    logic [15:0]        vco_cnt = '0;
    logic [5:0]         cfs;
    logic               busy, done, locked;
    logic signed [16:0] err;

    logic               start2 = 1'b0;
    logic [9:0]         n_div2 = '0;
    logic [15:0]        vco2 = '0;
    logic [5:0]         cfs2;
    logic               busy2, done2, locked2;
    logic signed [16:0] err2;

    logic [15:0]        model_k = 16'd100;
    logic               load = 1'b0;
    logic [15:0]        load_val = '0;
    int                 cyc = 0;

    typedef struct {
        int                 cyc;
        logic [5:0]         cfs;
        logic signed [16:0] err;
        logic               locked;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    int   checks = 0;
    int   failures = 0;

    vco_band_cal dut (
        .ref_clk(ref_clk), .rst(rst), .start(start), .n_div(n_div), .vco_cnt(vco_cnt),
        .cfs(cfs), .busy(busy), .done(done), .locked(locked), .err(err)
    );

    vco_band_cal #(.CAP_POL(0)) dut_neg (
        .ref_clk(ref_clk), .rst(rst), .start(start2), .n_div(n_div2), .vco_cnt(vco2),
        .cfs(cfs2), .busy(busy2), .done(done2), .locked(locked2), .err(err2)
    );

    always #5 ref_clk = ~ref_clk;

    always @(posedge ref_clk) begin
        cyc <= cyc + 1;
        if (load) vco_cnt <= load_val;
        else      vco_cnt <= vco_cnt + model_k - 16'(cfs);
        vco2 <= vco2 + 16'd37 + 16'(cfs2);
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge ref_clk) begin : monitor
        exp_t x;
        if (done) begin
            if (q1.size() == 0) chk("unexpected_done", done, 0);
            else begin
                x = q1.pop_front();
                chk("done_cycle", cyc, x.cyc);
                chk("cfs", cfs, x.cfs);
                chk("err", err, x.err);
                chk("locked", locked, x.locked);
                chk("busy_at_done", busy, 0);
            end
        end
        if (done2) begin
            if (q2.size() == 0) chk("unexpected_done2", done2, 0);
            else begin
                x = q2.pop_front();
                chk("done_cycle2", cyc, x.cyc);
                chk("cfs2", cfs2, x.cfs);
                chk("err2", err2, x.err);
                chk("locked2", locked2, x.locked);
            end
        end
    end

    task automatic launch(input logic [9:0] nd, input logic [5:0] ecfs,
                          input logic signed [16:0] eerr, input logic elock, input bit push);
        @(negedge ref_clk);
        n_div = nd;
        start = 1'b1;
        if (push) q1.push_back('{cyc + 295, ecfs, eerr, elock});
        @(negedge ref_clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic wait_done();
        int n = 0;
        while ((q1.size() != 0 || q2.size() != 0) && n < 400) begin
            @(negedge ref_clk);
            n++;
        end
        chk("done_timeout_q1", q1.size(), 0);
        chk("done_timeout_q2", q2.size(), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst = 1'b1;
        repeat (3) @(negedge ref_clk);
        chk("rst_cfs", cfs, 32);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_locked", locked, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;

        // Out-of-range target on both polarities.
        @(negedge ref_clk);
        n_div2 = 10'd20;
        start2 = 1'b1;
        q2.push_back('{cyc + 295, 6'd0, 17'sd544, 1'b0});
        @(negedge ref_clk);
        start2 = 1'b0;
        launch(10'd20, 6'd63, 17'sd544, 1'b0, 1'b1);
        wait_done();

        // Nominal lock; n_div change and a second start during the run are ignored.
        launch(10'd70, 6'd30, 17'sd0, 1'b1, 1'b1);
        n_div = 10'd5;
        repeat (49) @(negedge ref_clk);
        start = 1'b1;
        @(negedge ref_clk);
        start = 1'b0;
        chk("busy_mid_run", busy, 1);
        wait_done();

        // Counter preset near the top so measurement windows wrap.
        @(negedge ref_clk);
        load_val = 16'hFFF0;
        load = 1'b1;
        @(negedge ref_clk);
        load = 1'b0;
        launch(10'd70, 6'd30, 17'sd0, 1'b1, 1'b1);
        wait_done();

        // Reset mid-run: immediate clear, no done pulse afterwards.
        launch(10'd70, 6'd0, 17'sd0, 1'b0, 1'b0);
        repeat (99) @(negedge ref_clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_cfs", cfs, 32);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_locked", locked, 0);
        #1 rst = 1'b0;
        repeat (320) @(negedge ref_clk);
        chk("abort_busy_later", busy, 0);
        chk("abort_cfs_later", cfs, 32);

        // Lock again, then shift the VCO curve by one count per cycle.
        launch(10'd70, 6'd30, 17'sd0, 1'b1, 1'b1);
        n = 0;
        while (!done && n < 400) begin
            @(negedge ref_clk);
            n++;
        end
        chk("final_done_seen", done, 1);
        model_k = 16'd101;
`ifdef BAND_CAL_TRACK_EN
        n = 0;
        while (cfs != 6'd31 && n < 100) begin
            @(negedge ref_clk);
            n++;
        end
        chk("track_step_cfs", cfs, 31);
        chk("track_step_err", err, 32);
        chk("track_step_locked", locked, 0);
        chk("track_busy", busy, 0);
        repeat (60) @(negedge ref_clk);
        chk("track_relock_cfs", cfs, 31);
        chk("track_relock_err", err, 0);
        chk("track_relock_locked", locked, 1);
`else
        repeat (100) @(negedge ref_clk);
        chk("hold_cfs", cfs, 30);
        chk("hold_locked", locked, 1);
        chk("hold_err", err, 0);
`endif
        repeat (2) @(negedge ref_clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
